// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage and
// the MEM-stage data port.
//
// Fetch port : i_if_req, i_if_addr in; o_if_rdata, o_if_valid out.
// Data port  : i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata in;
//              o_dm_rdata, o_dm_valid out.
// Memory     : o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata out;
//              i_mem_ack, i_mem_rdata in (read data valid with ack).
// Pipeline   : o_stall_F, o_stall_M hold pipeline registers while the
//              matching request is outstanding.
// Status     : o_err pulses for one cycle when a grant times out.
//
// Data requests normally win. Fetch is guaranteed service after
// STARVE_LIMIT consecutive lost arbitrations. Completions are registered,
// so a request issued in cycle n produces its valid pulse no earlier than
// cycle n+2.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_if_valid,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    input  logic [DATA_WIDTH-1:0] i_dm_wdata,
    output logic [DATA_WIDTH-1:0] o_dm_rdata,
    output logic                  o_dm_valid,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_stall_F,
    output logic                  o_stall_M,
    output logic                  o_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT_IF = 2'd1;
    localparam logic [1:0] S_GNT_DM = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // Timeout fires on the edge where wait_cnt would reach TIMEOUT.
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    logic [1:0]            state_q,     state_d;
    logic [SW-1:0]         starve_q,    starve_d;
    logic [WW-1:0]         wait_q,      wait_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic                  if_valid_q,  if_valid_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
    logic                  dm_valid_q,  dm_valid_d;
    logic                  err_q,       err_d;
    logic                  fetch_win;

    // Fetch wins when alone, or when it has been starved long enough.
    assign fetch_win = i_if_req & (~i_dm_req | (starve_q == STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // i_mem_ack is deliberately ignored here.
                if (fetch_win) begin
                    state_d     = S_GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                    wait_d      = '0;
                end else if (i_dm_req) begin
                    state_d     = S_GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_dm_we;
                    mem_addr_d  = i_dm_addr;
                    mem_wdata_d = i_dm_wdata;
                    wait_d      = '0;
                    if (i_if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_GNT_IF, S_GNT_DM: begin
                if (i_mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == S_GNT_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = i_mem_rdata;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = i_mem_rdata;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Give up: complete the requester with zero data.
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == S_GNT_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_if_valid  = if_valid_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_dm_valid  = dm_valid_q;
    assign o_err       = err_q;

    // Stalls release combinationally in the valid cycle.
    assign o_stall_F = i_if_req & ~if_valid_q;
    assign o_stall_M = i_dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A cycle table covers a
// data read, a write and IF/DM contention; hand-written sequences cover
// starvation, timeout and reset in the middle of a grant.
module tb_mem_arbiter;

    localparam int OW = 135;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req, i_dm_req, i_dm_we, i_mem_ack;
    logic [31:0] i_if_addr, i_dm_addr, i_dm_wdata, i_mem_rdata;
    logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_valid, o_dm_valid, o_mem_req, o_mem_we;
    logic        o_stall_F, o_stall_M, o_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .o_dm_rdata(o_dm_rdata), .o_dm_valid(o_dm_valid),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_stall_F(o_stall_F), .o_stall_M(o_stall_M), .o_err(o_err)
    );

    typedef struct {
        logic        if_req, dm_req, dm_we, ack;
        logic [31:0] if_addr, dm_addr, dm_wdata, mrdata;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t T[21];

    // {mem_req, mem_we, mem_addr, mem_wdata, if_valid, dm_valid,
    //  if_rdata, dm_rdata, stall_F, stall_M, err}
    function automatic logic [OW-1:0] obs();
        return {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_if_valid,
                o_dm_valid, o_if_rdata, o_dm_rdata, o_stall_F, o_stall_M, o_err};
    endfunction

    function automatic vec_t mk(
        input logic ifr, input logic dmr, input logic we,
        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
        input logic ack, input logic [31:0] rd,
        input logic emr, input logic emw, input logic [31:0] ema,
        input logic [31:0] emwd, input logic eiv, input logic edv,
        input logic [31:0] eird, input logic [31:0] edrd,
        input logic esf, input logic esm, input logic eer);
        vec_t v;
        v.if_req = ifr; v.dm_req = dmr; v.dm_we = we; v.ack = ack;
        v.if_addr = ia; v.dm_addr = da; v.dm_wdata = wd; v.mrdata = rd;
        v.exp = {emr, emw, ema, emwd, eiv, edv, eird, edrd, esf, esm, eer};
        return v;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act,
                         input logic [OW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_if_req = 0; i_dm_req = 0; i_dm_we = 0; i_mem_ack = 0;
        i_if_addr = 0; i_dm_addr = 0; i_dm_wdata = 0; i_mem_rdata = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ngnt;
        logic [4:0]  gbits;
        int          cnt;
        logic        seen;
        int          nval;

        // ---------------- cycle table ----------------
        //          ifr dmr we  if_addr dm_addr  wdata         ack rdata
        //          | mreq mwe maddr  mwdata  ifv dmv ifrd  dmrd  stF stM err
        // data read, ack 2 cycles after o_mem_req
        T[0]  = mk(0,1,0, 0,'h100,0, 0,0,
                   0,0,0,0, 0,0, 0,0, 0,1,0);
        T[1]  = mk(0,1,0, 0,'h100,0, 0,0,
                   1,0,'h100,0, 0,0, 0,0, 0,1,0);
        T[2]  = mk(0,1,0, 0,'h100,0, 0,0,
                   1,0,'h100,0, 0,0, 0,0, 0,1,0);
        T[3]  = mk(0,1,0, 0,'h100,0, 1,'hDEADBEEF,
                   1,0,'h100,0, 0,0, 0,0, 0,1,0);
        T[4]  = mk(0,0,0, 0,'h100,0, 0,0,
                   0,0,'h100,0, 0,1, 0,'hDEADBEEF, 0,0,0);
        T[5]  = mk(0,0,0, 0,'h100,0, 0,0,
                   0,0,'h100,0, 0,0, 0,'hDEADBEEF, 0,0,0);
        // write: we/wdata held stable, dm_rdata untouched
        T[6]  = mk(0,1,1, 0,'h200,'h12345678, 0,0,
                   0,0,'h100,0, 0,0, 0,'hDEADBEEF, 0,1,0);
        T[7]  = mk(0,1,1, 0,'h200,'h12345678, 0,0,
                   1,1,'h200,'h12345678, 0,0, 0,'hDEADBEEF, 0,1,0);
        T[8]  = mk(0,1,1, 0,'h200,'h12345678, 0,0,
                   1,1,'h200,'h12345678, 0,0, 0,'hDEADBEEF, 0,1,0);
        T[9]  = mk(0,1,1, 0,'h200,'h12345678, 1,'hCAFEF00D,
                   1,1,'h200,'h12345678, 0,0, 0,'hDEADBEEF, 0,1,0);
        T[10] = mk(0,0,0, 0,0,0, 0,0,
                   0,1,'h200,'h12345678, 0,1, 0,'hDEADBEEF, 0,0,0);
        // contention, immediate acks: DM, IF, DM, IF
        T[11] = mk(1,1,0, 'h40,'h300,0, 0,0,
                   0,1,'h200,'h12345678, 0,0, 0,'hDEADBEEF, 1,1,0);
        T[12] = mk(1,1,0, 'h40,'h300,0, 1,'hAAAA0001,
                   1,0,'h300,0, 0,0, 0,'hDEADBEEF, 1,1,0);
        T[13] = mk(1,0,0, 'h40,'h300,0, 0,0,
                   0,0,'h300,0, 0,1, 0,'hAAAA0001, 1,0,0);
        T[14] = mk(1,1,0, 'h40,'h300,0, 1,'hBBBB0002,
                   1,0,'h40,0, 0,0, 0,'hAAAA0001, 1,1,0);
        T[15] = mk(0,1,0, 'h40,'h300,0, 0,0,
                   0,0,'h40,0, 1,0, 'hBBBB0002,'hAAAA0001, 0,1,0);
        T[16] = mk(1,1,0, 'h40,'h300,0, 1,'hAAAA0003,
                   1,0,'h300,0, 0,0, 'hBBBB0002,'hAAAA0001, 1,1,0);
        T[17] = mk(1,0,0, 'h40,'h300,0, 0,0,
                   0,0,'h300,0, 0,1, 'hBBBB0002,'hAAAA0003, 1,0,0);
        T[18] = mk(1,1,0, 'h40,'h300,0, 1,'hBBBB0004,
                   1,0,'h40,0, 0,0, 'hBBBB0002,'hAAAA0003, 1,1,0);
        T[19] = mk(0,0,0, 'h40,'h300,0, 0,0,
                   0,0,'h40,0, 1,0, 'hBBBB0004,'hAAAA0003, 0,0,0);
        T[20] = mk(0,0,0, 'h40,'h300,0, 0,0,
                   0,0,'h40,0, 0,0, 'hBBBB0004,'hAAAA0003, 0,0,0);

        // ---------------- reset state ----------------
        rst = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs(), '0);
        rst = 1;

        // ---------------- table ----------------
        for (int i = 0; i < 21; i++) begin
            i_if_req = T[i].if_req;   i_dm_req = T[i].dm_req;
            i_dm_we = T[i].dm_we;     i_mem_ack = T[i].ack;
            i_if_addr = T[i].if_addr; i_dm_addr = T[i].dm_addr;
            i_dm_wdata = T[i].dm_wdata; i_mem_rdata = T[i].mrdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(), T[i].exp);
            step();
        end

        // ---------------- starvation ----------------
        i_if_req = 1; i_if_addr = 'h40;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 'h300; i_dm_wdata = 0;
        i_mem_ack = 0;
        ngnt = 0; gbits = '0;
        for (int c = 0; c < 60 && ngnt < 5; c++) begin
            step();
            if (o_mem_req) begin
                gbits[ngnt] = (o_mem_addr == 'h40);
                if (ngnt == 4) check("starve_cnt_cleared", OW'(dut.starve_q), '0);
                ngnt++;
                i_mem_ack = 1;
                i_mem_rdata = 32'h5A000000 | c;
            end else begin
                i_mem_ack = 0;
            end
        end
        check("starve_grant_order", {ngnt[7:0], gbits}, {8'd5, 5'b10000});
        step();
        idle_inputs();
        check("starve_if_valid", {o_if_valid, o_dm_valid, o_mem_req}, 3'b100);
        step();

        // ---------------- timeout ----------------
        i_if_req = 1; i_if_addr = 'h80;
        cnt = 0; seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step();
            if (o_err) seen = 1;
            else if (o_mem_req) cnt++;
        end
        i_if_req = 0;
        check("timeout_grant_cycles", {seen, cnt[15:0]}, {1'b1, 16'd255});
        check("timeout_err_pulse", {o_err, o_if_valid, o_dm_valid, o_mem_req, o_if_rdata},
              {4'b1100, 32'h0});
        step();
        check("timeout_pulse_end", {o_err, o_if_valid, o_mem_req}, 3'b000);

        // ---------------- reset mid-grant ----------------
        i_dm_req = 1; i_dm_we = 1; i_dm_addr = 'h500; i_dm_wdata = 'h77;
        step();
        step();
        check("rst_pre_grant", {o_mem_req, o_mem_we, o_mem_addr}, {2'b11, 32'h500});
        rst = 0;
        idle_inputs();
        step();
        rst = 1;
        i_mem_ack = 1; i_mem_rdata = 'h99;
        nval = 0;
        step();
        i_mem_ack = 0; i_mem_rdata = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_dm_valid) nval++;
            step();
        end
        check("rst_no_valid", OW'(nval), '0);
        check("rst_outputs_zero", obs(), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
